main_memory: RTL and testbench

Block-organised data memory that answers the cache's miss traffic: the responder end of the cache-to-memory request/busywait interface. It serves whole 4-byte block reads (fetch on miss) and block writes (dirty write-back) with a fixed multi-cycle latency. It holds busywait high until the block is delivered or stored. It sits below `cache_memory` in the CPU data path and replaces the ad-hoc behavioural memory model.

---
 rtl/main_memory.sv | 141 ++++++++++++++
 tb/tb_main_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// ============================================================================
// main_memory
// ----------------------------------------------------------------------------
// Block-organised data memory responding to cache miss traffic. Serves whole
// 4-byte block reads and writes with a fixed LATENCY-edge service time and
// holds mem_busywait high until the access completes.
// Optional feature macro: MEM_CLEAR_ON_RESET_EN (reset also zeroes the array).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_memory #(
    parameter int LATENCY      = 5,
    parameter int DEPTH_BLOCKS = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_busywait
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [7:0] CNT_LOAD  = 8'(LATENCY - 1);
    localparam int         NUM_BYTES = DEPTH_BLOCKS * 4;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        op_write_q, op_write_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  mem_q [0:NUM_BYTES-1];
    logic        mem_we;
    logic [31:0] blk_rd;

    // Gather the four bytes of the latched block, byte 0 in the low lane
    always_comb begin
        blk_rd = {mem_q[{addr_q, 2'd3}], mem_q[{addr_q, 2'd2}],
                  mem_q[{addr_q, 2'd1}], mem_q[{addr_q, 2'd0}]};
    end

    // Next-state, request capture, latency countdown and completion actions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mem_we       = 1'b0;
        mem_busywait = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stall is visible in the same cycle the request is raised
                mem_busywait = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    // Write wins when both are raised together
                    op_write_d = mem_write;
                    addr_d     = mem_address;
                    wdata_d    = mem_writedata;
                    cnt_d      = CNT_LOAD;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_busywait = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                    if (op_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = blk_rd;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                // One quiet cycle lets the requester drop its request
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset aborts any access in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            op_write_q <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    // Byte array, zeroed by reset, written on write completion
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{addr_q, 2'(k)}] <= wdata_q[8*k +: 8];
            end
        end
    end
`else
    // Byte array, contents persist across reset, written on write completion
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{addr_q, 2'(k)}] <= wdata_q[8*k +: 8];
            end
        end
    end
`endif

    assign mem_readdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_main_memory.sv
// ============================================================================
// tb_main_memory
// ----------------------------------------------------------------------------
// Randomised plus directed stimulus against a byte-array reference model.
// Expected completions go into a queue; a monitor pops and checks them each
// time mem_busywait falls outside reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_memory;

    localparam int LAT = 5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [5:0]  mem_address = 6'd0;
    logic [31:0] mem_writedata = 32'd0;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    main_memory #(.LATENCY(LAT), .DEPTH_BLOCKS(64)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_rd = 32'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_block(input int a);
        return {ref_mem[a*4+3], ref_mem[a*4+2], ref_mem[a*4+1], ref_mem[a*4+0]};
    endfunction

    // Raise a request (called at posedge+1) and record its expected result
    task automatic start_req(input bit rd, input bit wr, input int a, input logic [31:0] d);
        exp_t e;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = 6'(a);
        mem_writedata = d;
        if (wr) begin
            for (int k = 0; k < 4; k++) ref_mem[a*4+k] = d[8*k +: 8];
            e.is_read = 1'b0;
            e.data    = last_rd;
        end else begin
            last_rd   = ref_block(a);
            e.is_read = 1'b1;
            e.data    = last_rd;
        end
        sb.push_back(e);
    endtask

    // Wait for busywait to fall; cyc counts posedges until it does
    task automatic wait_done(input int chg_at, output int cyc);
        bit done = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == chg_at) begin
                mem_address   = 6'h05;
                mem_writedata = $urandom;
            end
            if (!mem_busywait) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: busywait still %b after 20 cycles, required 0", mem_busywait);
        end
    endtask

    // Complete access: request, wait, check latency, drop, return in IDLE
    task automatic access(input bit rd, input bit wr, input int a, input logic [31:0] d);
        int cyc;
        start_req(rd, wr, a, d);
        #0;
        chk("busy_comb", 32'(mem_busywait), 32'd1);
        wait_done(0, cyc);
        chk("latency", 32'(cyc), 32'(LAT + 1));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        last_rd = 32'd0;
`ifdef MEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
`endif
        #1;
        chk("rst_rdata", mem_readdata, 32'd0);
        chk("rst_busy", 32'(mem_busywait), 32'd0);
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Monitor: every fall of busywait outside reset is one completion
    initial begin
        bit prev = 1'b0;
        int run  = 0;
        exp_t e;
        forever begin
            @(posedge CLK); #2;
            if (mem_busywait) begin
                run++;
            end else begin
                if (prev && RESET) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty: unexpected completion, readdata %h", mem_readdata);
                    end else begin
                        e = sb.pop_front();
                        chk(e.is_read ? "rd_data" : "wr_rdata_hold", mem_readdata, e.data);
                        chk("mon_busy_run", 32'(run), 32'(LAT + 1));
                    end
                end
                run = 0;
            end
            prev = mem_busywait;
        end
    end

    initial begin
        int cyc;
        logic [31:0] d;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("init_rdata", mem_readdata, 32'd0);
        chk("init_busy", 32'(mem_busywait), 32'd0);
        #2 RESET = 1'b1;
        @(posedge CLK); #1;

        // Fill every block so later reads never see X
        for (int a = 0; a < 64; a++) access(1'b0, 1'b1, a, $urandom);

        // Write then read, byte placement check
        access(1'b0, 1'b1, 2, 32'hDEADBEEF);
        chk("byte08", 32'(dut.mem_q[8'h08]), 32'h000000EF);
        access(1'b1, 1'b0, 2, 32'd0);

        // Read held through DONE: low for one cycle, next accept at E0+7
        start_req(1'b1, 1'b0, 9, 32'd0);
        wait_done(0, cyc);
        chk("hold_latency", 32'(cyc), 32'(LAT + 1));
        @(posedge CLK); #1;
        chk("hold_busy_again", 32'(mem_busywait), 32'd1);
        start_req(1'b1, 1'b0, 9, 32'd0);
        wait_done(0, cyc);
        chk("hold_second_latency", 32'(cyc), 32'(LAT + 1));
        mem_read = 1'b0;
        @(posedge CLK); #1;

        // Simultaneous read and write: write served, readdata unchanged
        access(1'b1, 1'b1, 6'h3F, 32'h12345678);
        access(1'b1, 1'b0, 6'h3F, 32'd0);

        // Address/data change after accept has no effect
        start_req(1'b0, 1'b1, 1, 32'hCAFEF00D);
        wait_done(3, cyc);
        chk("chg_latency", 32'(cyc), 32'(LAT + 1));
        mem_write = 1'b0;
        @(posedge CLK); #1;
        access(1'b1, 1'b0, 1, 32'd0);
        access(1'b1, 1'b0, 5, 32'd0);

        // Reset mid-write aborts the write
        mem_write = 1'b1;
        mem_address = 6'h04;
        mem_writedata = 32'hA5A5A5A5;
        repeat (4) @(posedge CLK);
        #1;
        pulse_reset();
        access(1'b1, 1'b0, 4, 32'd0);

        // Write all-ones, reset, read back
        access(1'b0, 1'b1, 6'h10, 32'hFFFFFFFF);
        pulse_reset();
        access(1'b1, 1'b0, 6'h10, 32'd0);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            d = $urandom;
            case ($urandom_range(0, 9))
                0:       access(1'b1, 1'b1, $urandom_range(0, 63), d);
                1, 2, 3, 4: access(1'b0, 1'b1, $urandom_range(0, 63), d);
                default: access(1'b1, 1'b0, $urandom_range(0, 63), d);
            endcase
        end

        repeat (5) @(posedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
